// File: rtl/seq_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock through a ripple chain
// with a registered carry, wrapped in a start/busy/done handshake.
module seq_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // state | meaning
  // IDLE  | waiting for start; results from the last op held
  // RUN   | one DIGIT-wide slice of the operands per clock
  // DONE  | single-cycle done pulse, results valid
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] dsum;
  logic [WIDTH-1:0] a_shift, b_shift, sum_next;

  always_comb begin
    c    = '0;
    dsum = '0;
    c[0] = carry;
    for (int i = 0; i < DIGIT; i++) begin
      dsum[i]  = a_reg[i] ^ b_reg[i] ^ c[i];
      c[i+1]   = (a_reg[i] & b_reg[i]) | (c[i] & (a_reg[i] ^ b_reg[i]));
    end
  end

  // A full-width digit consumes the operands in one step, so nothing shifts down.
  if (DIGIT == WIDTH) begin : g_full
    assign a_shift  = '0;
    assign b_shift  = '0;
    assign sum_next = dsum;
  end else begin : g_part
    assign a_shift  = {{DIGIT{1'b0}}, a_reg[WIDTH-1:DIGIT]};
    assign b_shift  = {{DIGIT{1'b0}}, b_reg[WIDTH-1:DIGIT]};
    assign sum_next = {dsum, sum[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_reg <= a_shift;
          b_reg <= b_shift;
          carry <= c[DIGIT];
          sum   <= sum_next;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            cout  <= c[DIGIT];
            ovf   <= c[DIGIT-1] ^ c[DIGIT];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_adder.sv
// Bench for seq_adder: several WIDTH/DIGIT configurations in parallel, each with
// a result queue filled at issue time and drained by a done-triggered monitor.
module tb_seq_adder;

  localparam int NCFG     = 7;
  localparam int RAND_OPS = 143;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int fin_count = 0;

  function automatic int cfg_w(int i);
    return (i < 4) ? 8 : 16;
  endfunction

  function automatic int cfg_d(int i);
    case (i)
      0: return 1;
      1: return 2;
      2: return 4;
      3: return 8;
      4: return 1;
      5: return 2;
      default: return 16;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Golden result {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [17:0] model(int w, logic [15:0] av, logic [15:0] bv, logic sv);
    longint m, h, ua, ub, r, sa, sb, sr;
    logic cy, ov;
    m  = longint'(1) << w;
    h  = m / 2;
    ua = longint'(av) % m;
    ub = longint'(bv) % m;
    if (sv) begin
      r  = ua - ub + m;
      cy = (ua >= ub);
    end else begin
      r  = ua + ub;
      cy = (r >= m);
    end
    sa = (ua >= h) ? ua - m : ua;
    sb = (ub >= h) ? ub - m : ub;
    sr = sv ? sa - sb : sa + sb;
    ov = (sr < -h) || (sr >= h);
    r  = r % m;
    return {ov, cy, 16'(r)};
  endfunction

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int W = cfg_w(gi);
    localparam int D = cfg_d(gi);
    localparam int N = W / D;

    logic         rst_n, start, sub;
    logic [W-1:0] a, b, sum;
    logic         busy, done, cout, ovf;
    logic [17:0]  q[$];
    logic [17:0]  exp_e;
    string        tag;

    initial tag = $sformatf("W%0d_D%0d", W, D);

    seq_adder #(.WIDTH(W), .DIGIT(D)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always @(negedge clk) begin
      if (done === 1'b1) begin
        check({tag, " done_not_busy"}, 64'(busy), 64'd0);
        if (q.size() == 0) begin
          check({tag, " unexpected_done"}, 64'd1, 64'd0);
        end else begin
          exp_e = q.pop_front();
          check({tag, " sum"},  64'(sum),  64'(exp_e[W-1:0]));
          check({tag, " cout"}, 64'(cout), 64'(exp_e[16]));
          check({tag, " ovf"},  64'(ovf),  64'(exp_e[17]));
        end
      end
    end

    task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check({tag, " reset_outputs"}, 64'({busy, done, sum, cout, ovf}), 64'd0);
      rst_n = 1'b1;
    endtask

    // Returns 1 ns after the accepting edge with start dropped and operands scrambled.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                         input logic [17:0] e, input bit push);
      @(negedge clk);
      a = av; b = bv; sub = sv; start = 1'b1;
      if (push) q.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    endtask

    task automatic drain();
      int k;
      k = 0;
      while (q.size() != 0 && k < 200) begin
        @(negedge clk);
        k++;
      end
      check({tag, " drain"}, 64'(q.size()), 64'd0);
      @(negedge clk);
    endtask

    task automatic random_phase();
      repeat (RAND_OPS) begin
        @(negedge clk);
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        start = 1'b1;
        q.push_back(model(W, 16'(a), 16'(b), sub));
        @(posedge clk);
        #1;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        repeat (N + 1) @(posedge clk);
      end
      @(negedge clk);
      start = 1'b0;
      drain();
    endtask

    if (W == 8 && D == 1) begin : g_dir1
      initial begin
        int dc;
        do_reset();
        // Start re-pulsed mid-run must be ignored; also pins done latency.
        issue(8'h5A, 8'h3C, 1'b0, {1'b1, 1'b0, 16'h0096}, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1; a = 8'h01; b = 8'h01;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (N - 4) @(posedge clk);
        #1 check({tag, " latency_early"}, 64'(done), 64'd0);
        @(posedge clk);
        #1 check({tag, " latency_done"}, 64'(done), 64'd1);
        drain();
        issue(8'h01, 8'h01, 1'b0, {1'b0, 1'b0, 16'h0002}, 1'b1);
        drain();
        issue(8'h10, 8'h20, 1'b1, {1'b0, 1'b0, 16'h00F0}, 1'b1);
        drain();
        issue(8'h20, 8'h10, 1'b1, {1'b0, 1'b1, 16'h0010}, 1'b1);
        drain();
        repeat (5) @(negedge clk);
        check({tag, " hold_result"}, 64'({sum, cout, ovf}), 64'({8'h10, 1'b1, 1'b0}));
        // Abort by reset at E0+4.
        issue(8'h5A, 8'h3C, 1'b0, 18'd0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 check({tag, " abort_clear"}, 64'({busy, done, sum, cout, ovf}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dc = 0;
        repeat (N + 4) begin
          @(negedge clk);
          if (done === 1'b1) dc++;
        end
        check({tag, " abort_no_done"}, 64'(dc), 64'd0);
        random_phase();
        fin_count++;
      end
    end else if (W == 8 && D == 4) begin : g_dir4
      initial begin
        int bc;
        do_reset();
        issue(8'hFF, 8'h01, 1'b0, {1'b0, 1'b1, 16'h0000}, 1'b1);
        bc = 0;
        repeat (4) begin
          @(negedge clk);
          if (busy === 1'b1) bc++;
        end
        check({tag, " busy_cycles"}, 64'(bc), 64'd2);
        drain();
        issue(8'h80, 8'h01, 1'b1, {1'b1, 1'b1, 16'h007F}, 1'b1);
        drain();
        random_phase();
        fin_count++;
      end
    end else begin : g_rand
      initial begin
        do_reset();
        random_phase();
        fin_count++;
      end
    end
  end

  initial begin
    int k;
    k = 0;
    while (fin_count < NCFG && k < 60000) begin
      @(posedge clk);
      k++;
    end
    check("all_configs_finished", 64'(fin_count), 64'(NCFG));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
